// File: rtl/wb_buf_slave.sv
// wb_buf_slave: Wishbone responder backed by a DEPTH x 64-bit dual-lane buffer.
// Terminates single beats and cab bursts with registered ack/err/rty and read data.
module wb_buf_slave #(
    parameter int          AW       = 6,
    parameter logic [31:0] BASE_ADR = 32'h0000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cab_i,
    input  logic        wbs_pref_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_dat64_i,
    input  logic        hold_i,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] wbs_dat64_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        wbs_rty_o
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [2:0] {IDLE, WR, RD0, RD, TERM} state_t;

    state_t        state;
    state_t        state_d;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_d;
    logic [AW-1:0] idx_inc;
    logic [AW-1:0] adr_idx;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          ack_d;
    logic          err_d;
    logic          rty_d;
    logic          mem_we;
    logic          rd_en;
    logic          req;
    logic          decode_err;
    logic [63:0]   mem [DEPTH];

    // A prefetch is treated exactly like a read, so the hint carries no function here.
    logic          unused_pref;
    assign unused_pref = wbs_pref_i;

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign adr_idx = wbs_adr_i[AW+2:3];
    assign idx_inc = idx + AW'(1);

    // Out-of-window address, misaligned beat or partial-word write all terminate with err.
    assign decode_err = (wbs_adr_i[31:AW+3] != BASE_ADR[31:AW+3])
                      | (wbs_adr_i[2:0] != 3'b000)
                      | (wbs_we_i & (wbs_sel_i != 4'hF));

    // State, beat index and the registered handshake outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            idx       <= '0;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_rty_o <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            wbs_ack_o <= ack_d;
            wbs_err_o <= err_d;
            wbs_rty_o <= rty_d;
        end
    end

    // Next-state decode: one terminate per request, one beat per clock inside a burst.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rty_d   = 1'b0;
        mem_we  = 1'b0;
        wr_addr = idx;
        rd_en   = 1'b0;
        rd_addr = idx;
        case (state)
            IDLE: begin
                if (req) begin
                    if (decode_err) begin
                        err_d   = 1'b1;
                        state_d = TERM;
                    end else if (hold_i) begin
                        rty_d   = 1'b1;
                        state_d = TERM;
                    end else begin
                        idx_d = adr_idx;
                        if (wbs_we_i) begin
                            mem_we  = 1'b1;
                            wr_addr = adr_idx;
                            ack_d   = 1'b1;
                            state_d = WR;
                        end else begin
                            state_d = RD0;
                        end
                    end
                end
            end
            WR: begin
                if (wbs_cab_i && req) begin
                    idx_d   = idx_inc;
                    mem_we  = 1'b1;
                    wr_addr = idx_inc;
                    ack_d   = 1'b1;
                end else begin
                    state_d = TERM;
                end
            end
            RD0: begin
                rd_en   = 1'b1;
                rd_addr = idx;
                ack_d   = 1'b1;
                state_d = RD;
            end
            RD: begin
                if (wbs_cab_i && req) begin
                    idx_d   = idx_inc;
                    rd_en   = 1'b1;
                    rd_addr = idx_inc;
                    ack_d   = 1'b1;
                end else begin
                    state_d = TERM;
                end
            end
            TERM: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Buffer write port; contents deliberately survive reset.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we) begin
            mem[wr_addr] <= {wbs_dat64_i, wbs_dat_i};
        end
    end

    // Read data register; loads only with an acked read beat and otherwise holds.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_dat_o   <= '0;
            wbs_dat64_o <= '0;
        end else if (rd_en) begin
            wbs_dat_o   <= mem[rd_addr][31:0];
            wbs_dat64_o <= mem[rd_addr][63:32];
        end
    end

endmodule

// File: doc/wb_buf_slave.md
Name: wb_buf_slave

Overview:
- Wishbone responder that sits at the far end of the channel mixer's master port and terminates its cyc/stb/we/cab/pref traffic.
- Backed by a local dual-lane buffer, DEPTH x (32-bit dat lane + 32-bit dat64 lane).
- Returns ack/err/rty plus read data on both lanes.
- Supports single beats and cab bursts with an internal address counter.

Parameters:
- AW, 6: log2 of buffer depth in 64-bit beats (DEPTH = 2^AW).
- BASE_ADR, 32'h0000_0000: decode base; only bits [31:AW+3] are compared.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i  in  1  cycle valid.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write.
- wbs_cab_i  in  1  consecutive-address burst.
- wbs_pref_i  in  1  prefetch hint; functionally identical to a read.
- wbs_sel_i  in  4  byte select.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data, low lane.
- wbs_dat64_i  in  32  write data, high lane.
- hold_i  in  1  buffer locked by the local engine; forces retry.
- wbs_dat_o  out  32  read data, low lane.
- wbs_dat64_o  out  32  read data, high lane.
- wbs_ack_o  out  1  beat acknowledge.
- wbs_err_o  out  1  error terminate.
- wbs_rty_o  out  1  retry terminate.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is asynchronous and active-high.
- While reset is asserted: ack/err/rty = 0, dat_o/dat64_o = 0, FSM = IDLE, beat counter = 0. Buffer contents are not cleared.
- Reset mid-burst: outputs drop on the reset edge, and no further buffer writes occur.
- Request: req = cyc & stb, sampled on the rising edge. All outputs are registered.
- Decode checks, evaluated in IDLE on req:
  - err if adr[31:AW+3] != BASE_ADR[31:AW+3].
  - err if adr[2:0] != 0.
  - err if we=1 and sel != 4'hF.
  - Otherwise rty if hold_i = 1.
  - Otherwise start a transfer with idx = adr[AW+2:3].
- Priority: err > rty > ack.
- err or rty pulse for exactly 1 cycle. No buffer access occurs on err or rty.
- hold_i is sampled only in IDLE; hold_i rising mid-burst does not affect that burst.
- FSM states: IDLE, WR, RD0, RD, TERM.
- IDLE -> WR (we=1), RD0 (we=0), TERM (err/rty).
- WR:
  - ack=1 the cycle after the beat is sampled; mem[idx] <= {dat64_i, dat_i} on that same sampling edge.
  - Single beat (cab=0): -> TERM. TERM holds all outputs 0 for one cycle, then -> IDLE. This gives a 2-cycle minimum per single beat.
  - cab=1 and req still high: stay in WR, idx <= idx+1, ack each cycle (one beat per clock). The master address is ignored after the first beat.
- RD0: buffer read cycle (1-cycle RAM latency). -> RD.
- RD:
  - ack=1, with dat_o/dat64_o = the beat at idx.
  - cab=1 and req high: prefetch idx+1, giving back-to-back acks.
  - Otherwise -> TERM.
  - First-beat read latency = 2 cycles from sampled req to ack.
- Burst termination: stb, cyc or cab low in WR/RD ends the burst -> TERM. Any prefetched word is discarded, with no ack for it. The next req restarts from decode.
- Wrap-around: idx is AW bits and wraps from DEPTH-1 to 0 inside a burst. No err is raised on wrap.
- dat_o/dat64_o hold their last value when ack=0. They are 0 only after reset.
- ack, err and rty are mutually exclusive in every cycle.

Test Plan:
- Reset sequencing: assert wb_rst_i mid read burst -> ack/dat_o go 0 immediately. After release, a single read of adr 0x08 returns the previously written data.
- Single write then read: write adr 0x10, dat 0xA5A5_0001, dat64 0x5A5A_0002 -> ack 1 cycle after sample. Read adr 0x10 -> ack 2 cycles after req, dat_o = 0xA5A5_0001, dat64_o = 0x5A5A_0002.
- Burst wrap: cab write of 4 beats starting at adr 0x1F0 (idx 62, AW=6), data 1..4 -> ack on 4 consecutive cycles. Read idx 62, 63, 0, 1 -> 1, 2, 3, 4.
- Errors: adr 0x0000_0204 -> err, 1 cycle. adr 0x0000_0004 -> err. Write with sel = 4'h3 -> err, and the buffer is unchanged.
- Retry: hold_i = 1 with a read req -> rty for 1 cycle, no ack. hold_i asserted during the 2nd beat of an 8-beat cab read -> all 8 acks delivered.
- Early termination: drop stb after 2 beats of a cab read -> exactly 2 acks, then TERM. The next single read at the original address returns the correct data.
